// File: rtl/aux_lut_reader.sv
// AUX DAC table reader: turns an (AUX_A, AUX_B) code pair into two 32-bit table words
// through one shared read port, with an optional last-code cache per channel.
module aux_lut_reader #(
  parameter logic [23:0] A_BASE   = 24'h000000,
  parameter logic [23:0] B_BASE   = 24'h000000,
  parameter bit          CACHE_EN = 1'b1
) (
  input  logic        CLK,
  input  logic        n_RES,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  AUX_A,
  input  logic [14:0] AUX_B,
  output logic        mem_rd,
  output logic [23:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] AOut,
  output logic [31:0] BOut
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ_A  = 3'd1,
    WAIT_A = 3'd2,
    REQ_B  = 3'd3,
    WAIT_B = 3'd4,
    OUT    = 3'd5
  } state_t;

  state_t      state_reg;
  logic [7:0]  code_a_reg;
  logic [14:0] code_b_reg;
  logic [7:0]  last_a_reg;
  logic [14:0] last_b_reg;
  logic        a_cv_reg;
  logic        b_cv_reg;

  logic        a_hit_in;
  logic        b_hit;
  logic [23:0] addr_a_in;
  logic [23:0] addr_b;

  // The A hit is judged on the incoming code so the REQ_A read pulse can be registered at accept.
  assign a_hit_in  = CACHE_EN && a_cv_reg && (AUX_A == last_a_reg);
  assign b_hit     = CACHE_EN && b_cv_reg && (code_b_reg == last_b_reg);
  assign addr_a_in = A_BASE + {16'b0, AUX_A};
  assign addr_b    = B_BASE + {9'b0, code_b_reg};

  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      state_reg  <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      mem_rd     <= 1'b0;
      mem_addr   <= 24'h0;
      AOut       <= 32'h0;
      BOut       <= 32'h0;
      code_a_reg <= 8'h0;
      code_b_reg <= 15'h0;
      last_a_reg <= 8'h0;
      last_b_reg <= 15'h0;
      a_cv_reg   <= 1'b0;
      b_cv_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready) begin
            code_a_reg <= AUX_A;
            code_b_reg <= AUX_B;
            in_ready   <= 1'b0;
            state_reg  <= REQ_A;
            if (!a_hit_in) begin
              mem_rd   <= 1'b1;
              mem_addr <= addr_a_in;
            end
          end
        end
        // mem_rd high here means the A lookup missed and its pulse is on the bus now.
        REQ_A: begin
          if (mem_rd) begin
            mem_rd    <= 1'b0;
            state_reg <= WAIT_A;
          end else begin
            state_reg <= REQ_B;
            if (!b_hit) begin
              mem_rd   <= 1'b1;
              mem_addr <= addr_b;
            end
          end
        end
        WAIT_A: begin
          if (mem_rvalid) begin
            AOut       <= mem_rdata;
            last_a_reg <= code_a_reg;
            a_cv_reg   <= 1'b1;
            state_reg  <= REQ_B;
            if (!b_hit) begin
              mem_rd   <= 1'b1;
              mem_addr <= addr_b;
            end
          end
        end
        REQ_B: begin
          if (mem_rd) begin
            mem_rd    <= 1'b0;
            state_reg <= WAIT_B;
          end else begin
            out_valid <= 1'b1;
            state_reg <= OUT;
          end
        end
        WAIT_B: begin
          if (mem_rvalid) begin
            BOut       <= mem_rdata;
            last_b_reg <= code_b_reg;
            b_cv_reg   <= 1'b1;
            out_valid  <= 1'b1;
            state_reg  <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          mem_rd    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aux_lut_reader.sv
// Directed bench for aux_lut_reader: latency, cache hits, address wrap, output stall and reset mid-fetch.
module tb_aux_lut_reader;

  logic        clk = 1'b0;
  logic        n_res = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  aux_a = 8'h0;
  logic [14:0] aux_b = 15'h0;
  logic        mem_rd;
  logic [23:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] aout;
  logic [31:0] bout;

  logic        w_in_valid = 1'b0;
  logic        w_in_ready;
  logic [7:0]  w_aux_a = 8'h0;
  logic [14:0] w_aux_b = 15'h0;
  logic        w_mem_rd;
  logic [23:0] w_mem_addr;
  logic [31:0] w_mem_rdata;
  logic        w_mem_rvalid;
  logic        w_out_valid;
  logic        w_out_ready = 1'b1;
  logic [31:0] w_aout;
  logic [31:0] w_bout;

  int          lat = 1;
  int          resp_cnt;
  logic [23:0] resp_addr;
  logic        force_rv = 1'b0;
  logic [23:0] addr_log[$];
  logic [23:0] w_addr_log[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  aux_lut_reader #(.A_BASE(24'h000000), .B_BASE(24'h000100), .CACHE_EN(1'b1)) u_dut (
    .CLK(clk), .n_RES(n_res), .in_valid(in_valid), .in_ready(in_ready),
    .AUX_A(aux_a), .AUX_B(aux_b), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .out_valid(out_valid),
    .out_ready(out_ready), .AOut(aout), .BOut(bout)
  );

  aux_lut_reader #(.A_BASE(24'h000000), .B_BASE(24'hFFFFF0), .CACHE_EN(1'b0)) u_wrap (
    .CLK(clk), .n_RES(n_res), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .AUX_A(w_aux_a), .AUX_B(w_aux_b), .mem_rd(w_mem_rd), .mem_addr(w_mem_addr),
    .mem_rdata(w_mem_rdata), .mem_rvalid(w_mem_rvalid), .out_valid(w_out_valid),
    .out_ready(w_out_ready), .AOut(w_aout), .BOut(w_bout)
  );

  function automatic logic [31:0] mw(input logic [23:0] a);
    return {8'h5A, a} ^ 32'h00A55A00;
  endfunction

  // Memory model: answers each read exactly lat cycles after the mem_rd cycle.
  always @(posedge clk or negedge n_res) begin
    if (!n_res) begin
      resp_cnt  <= 0;
      resp_addr <= 24'h0;
    end else if (mem_rd) begin
      resp_cnt  <= lat;
      resp_addr <= mem_addr;
      addr_log.push_back(mem_addr);
    end else if (resp_cnt > 0) begin
      resp_cnt <= resp_cnt - 1;
    end
  end

  assign mem_rvalid = (resp_cnt == 1) || force_rv;
  assign mem_rdata  = force_rv ? 32'hDEADBEEF : mw(resp_addr);

  always @(posedge clk or negedge n_res) begin
    if (!n_res) begin
      w_mem_rvalid <= 1'b0;
      w_mem_rdata  <= 32'h0;
    end else begin
      w_mem_rvalid <= w_mem_rd;
      w_mem_rdata  <= mw(w_mem_addr);
      if (w_mem_rd) w_addr_log.push_back(w_mem_addr);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_pair(input logic [7:0] a, input logic [14:0] b, input int lat_cfg,
                          input logic [31:0] ea, input logic [31:0] eb, input int elat,
                          input int erds, input logic [23:0] ad0, input logic [23:0] ad1,
                          input bit stall);
    int cyc;
    lat = lat_cfg;
    out_ready = !stall;
    addr_log.delete();
    aux_a = a;
    aux_b = b;
    in_valid = 1'b1;
    tick();
    check_eq("accepted", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 60) begin
      tick();
      cyc++;
    end
    check_eq("latency", 32'(cyc), 32'(elat));
    check_eq("aout", aout, ea);
    check_eq("bout", bout, eb);
    check_eq("rd_count", 32'(addr_log.size()), 32'(erds));
    if (erds >= 1 && addr_log.size() >= 1) check_eq("addr0", 32'(addr_log[0]), 32'(ad0));
    if (erds >= 2 && addr_log.size() >= 2) check_eq("addr1", 32'(addr_log[1]), 32'(ad1));
    if (stall) begin
      for (int i = 0; i < 10; i++) begin
        tick();
        check_eq("stall_valid", 32'(out_valid), 32'd1);
        check_eq("stall_aout", aout, ea);
        check_eq("stall_bout", bout, eb);
        check_eq("stall_ready", 32'(in_ready), 32'd0);
        check_eq("stall_rd", 32'(addr_log.size()), 32'(erds));
      end
      out_ready = 1'b1;
    end
    tick();
    check_eq("done_valid", 32'(out_valid), 32'd0);
    check_eq("done_ready", 32'(in_ready), 32'd1);
    $display("pair A=%h B=%h lat=%0d aout=%h bout=%h reads=%0d", a, b, cyc, aout, bout, addr_log.size());
  endtask

  initial begin
    // Reset with in_valid held high
    in_valid = 1'b1;
    aux_a = 8'h05;
    aux_b = 15'h0003;
    repeat (2) tick();
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_mem_rd", 32'(mem_rd), 32'd0);
    check_eq("rst_aout", aout, 32'h0);
    check_eq("rst_bout", bout, 32'h0);
    n_res = 1'b1;

    // Cold fetch, then full hit, then B-only miss, then A-only miss with L=3
    run_pair(8'h05, 15'h0003, 1, 32'h5AA55A05, 32'h5AA55B03, 5, 2, 24'h000005, 24'h000103, 1'b0);
    run_pair(8'h05, 15'h0003, 1, 32'h5AA55A05, 32'h5AA55B03, 3, 0, 24'h0, 24'h0, 1'b0);
    run_pair(8'h05, 15'h0007, 1, 32'h5AA55A05, 32'h5AA55B07, 4, 1, 24'h000107, 24'h0, 1'b0);
    run_pair(8'h09, 15'h0007, 3, 32'h5AA55A09, 32'h5AA55B07, 6, 1, 24'h000009, 24'h0, 1'b0);

    // Consumer stall on an all-hit pair
    run_pair(8'h09, 15'h0007, 1, 32'h5AA55A09, 32'h5AA55B07, 3, 0, 24'h0, 24'h0, 1'b1);

    // B address wraps modulo 2^24
    w_aux_a = 8'h00;
    w_aux_b = 15'h0020;
    w_in_valid = 1'b1;
    tick();
    w_in_valid = 1'b0;
    repeat (8) tick();
    check_eq("wrap_rds", 32'(w_addr_log.size()), 32'd2);
    if (w_addr_log.size() >= 2) check_eq("wrap_addr", 32'(w_addr_log[1]), 32'h000010);
    check_eq("wrap_bout", w_bout, 32'h5AA55A10);
    $display("wrap B=%h bout=%h reads=%0d", w_aux_b, w_bout, w_addr_log.size());

    // Reset during WAIT_A, then a stale strobe
    lat = 4;
    aux_a = 8'h12;
    aux_b = 15'h0044;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    n_res = 1'b0;
    #1;
    check_eq("midrst_aout", aout, 32'h0);
    check_eq("midrst_ready", 32'(in_ready), 32'd1);
    tick();
    n_res = 1'b1;
    force_rv = 1'b1;
    tick();
    force_rv = 1'b0;
    check_eq("stale_aout", aout, 32'h0);
    check_eq("stale_bout", bout, 32'h0);
    check_eq("stale_ready", 32'(in_ready), 32'd1);
    check_eq("stale_valid", 32'(out_valid), 32'd0);
    check_eq("stale_rd", 32'(mem_rd), 32'd0);
    $display("stale strobe aout=%h bout=%h in_ready=%0d", aout, bout, in_ready);
    run_pair(8'h09, 15'h0007, 1, 32'h5AA55A09, 32'h5AA55B07, 5, 2, 24'h000009, 24'h000107, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
